// File: rtl/clk_div_switch_pkg.sv
// Shared types for the divided-clock generator and glitch-free source switch.
package clk_div_switch_pkg;

  typedef enum logic [1:0] {
    StIdle       = 2'd0,
    StWaitOldLow = 2'd1,
    StWaitNewLow = 2'd2
  } sw_state_e;

  // Source 0 is clk_a, source 1 is clk_b.
  function automatic logic pick_src(input logic sel, input logic a, input logic b);
    return sel ? b : a;
  endfunction

endpackage

// File: rtl/clk_div_gen.sv
// Programmable half-period divider: output toggles every max(div,1) cycles of clk.
module clk_div_gen
  import clk_div_switch_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] div,
  output logic             clk_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] div_eff;
  logic             term;

  assign div_eff = (div == '0) ? CNT_W'(1) : div;
  assign term    = (cnt_q == half_q - CNT_W'(1));

  // half_q is reloaded only at terminal count so a new div never cuts a half-period short.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      half_q <= div_eff;
      clk_o  <= 1'b0;
    end else if (term) begin
      cnt_q  <= '0;
      half_q <= div_eff;
      clk_o  <= ~clk_o;
    end else begin
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clk_div_switch.sv
// Two programmable clock dividers feeding a registered, glitch-free source switch.
module clk_div_switch
  import clk_div_switch_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] div_a,
  input  logic [CNT_W-1:0] div_b,
  input  logic             sel_req,
  output logic             clk_a,
  output logic             clk_b,
  output logic             clk_out,
  output logic             sel_cur,
  output logic             busy
);

  sw_state_e state_q;
  logic      tgt_q;
  logic      clk_a_d;
  logic      clk_b_d;
  logic      src_cur;
  logic      tgt_fall;

  clk_div_gen #(
    .CNT_W (CNT_W)
  ) u_div_a (
    .clk   (clk),
    .rst   (rst),
    .div   (div_a),
    .clk_o (clk_a)
  );

  clk_div_gen #(
    .CNT_W (CNT_W)
  ) u_div_b (
    .clk   (clk),
    .rst   (rst),
    .div   (div_b),
    .clk_o (clk_b)
  );

  assign src_cur  = pick_src(sel_cur, clk_a, clk_b);
  assign tgt_fall = pick_src(tgt_q, clk_a_d, clk_b_d) & ~pick_src(tgt_q, clk_a, clk_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tgt_q   <= 1'b0;
      clk_a_d <= 1'b0;
      clk_b_d <= 1'b0;
      clk_out <= 1'b0;
      sel_cur <= 1'b0;
      busy    <= 1'b0;
    end else begin
      clk_a_d <= clk_a;
      clk_b_d <= clk_b;
      case (state_q)
        StIdle: begin
          clk_out <= src_cur;
          if (sel_req != sel_cur) begin
            tgt_q   <= sel_req;
            busy    <= 1'b1;
            state_q <= StWaitOldLow;
          end
        end
        // Let the current high phase finish; park low once the old source is seen low.
        StWaitOldLow: begin
          clk_out <= src_cur;
          if (!src_cur) state_q <= StWaitNewLow;
        end
        // Hand over only on a falling edge of the new source, so its next high is whole.
        StWaitNewLow: begin
          clk_out <= 1'b0;
          if (tgt_fall) begin
            sel_cur <= tgt_q;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          clk_out <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
